// File: rtl/cordic_rotation_engine_if.sv
// Angle request / cos-sin result handshake between upstream logic and the
// CORDIC rotation engine.
interface cordic_rotation_engine_if #(
  parameter int N_FRAC = 15
);
  logic signed [N_FRAC:0] angle_i;
  logic                   valid_i;
  logic                   ready_o;
  logic signed [N_FRAC:0] cos_o;
  logic signed [N_FRAC:0] sin_o;
  logic                   valid_o;

  modport master (output angle_i, valid_i, input ready_o, cos_o, sin_o, valid_o);
  modport slave  (input angle_i, valid_i, output ready_o, cos_o, sin_o, valid_o);
endinterface

// File: rtl/cordic_rotation_engine.sv
// Iterative rotation-mode CORDIC: quadrant pre-rotation, gain pre-scaling,
// then one micro-rotation per cycle on a shared datapath.
module cordic_rotation_engine #(
  parameter int N_FRAC         = 15,
  parameter int BW_SHIFT_VALUE = 4,
  parameter int N_ITER         = 15
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  cordic_rotation_engine_if.slave   io
);
  localparam int W  = N_FRAC + 1;
  localparam int XW = N_FRAC + 2;
  localparam logic signed [XW-1:0] K      = XW'(19896);
  localparam logic signed [XW-1:0] SAT_HI = XW'(2**N_FRAC - 1);
  localparam logic signed [XW-1:0] SAT_LO = -SAT_HI;
  // atan(2^-i) with 1.0 == pi, Q1.15
  localparam logic [15:0] ATAN [16] = '{16'd8192, 16'd4836, 16'd2555, 16'd1297,
                                        16'd651,  16'd326,  16'd163,  16'd81,
                                        16'd41,   16'd20,   16'd10,   16'd5,
                                        16'd3,    16'd1,    16'd1,    16'd0};

  typedef enum logic [1:0] {IDLE, ROTATE, DONE} state_e;

  state_e                    state_q, state_d;
  logic signed [XW-1:0]      x_q, x_d, y_q, y_d;
  logic signed [W-1:0]       z_q, z_d;
  logic [BW_SHIFT_VALUE-1:0] i_q, i_d;
  logic signed [W-1:0]       cos_q, cos_d, sin_q, sin_d;
  logic                      valid_q, valid_d;

  logic signed [W-1:0]       atan_c;
  logic signed [XW-1:0]      x_sh, y_sh;
  logic                      outside;

  function automatic logic signed [W-1:0] sat(input logic signed [XW-1:0] v);
    if (v > SAT_HI)      return SAT_HI[W-1:0];
    else if (v < SAT_LO) return SAT_LO[W-1:0];
    else                 return v[W-1:0];
  endfunction

  assign atan_c  = W'(ATAN[i_q]);
  assign x_sh    = x_q >>> i_q;
  assign y_sh    = y_q >>> i_q;
  assign outside = io.angle_i[N_FRAC] ^ io.angle_i[N_FRAC-1];

  always_comb begin
    state_d = state_q;
    x_d     = x_q;
    y_d     = y_q;
    z_d     = z_q;
    i_d     = i_q;
    cos_d   = cos_q;
    sin_d   = sin_q;
    valid_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (io.valid_i) begin
          // Fold the left half-plane onto the right by rotating pi and negating x
          z_d     = outside ? {~io.angle_i[N_FRAC], io.angle_i[N_FRAC-1:0]} : io.angle_i;
          x_d     = outside ? -K : K;
          y_d     = '0;
          i_d     = '0;
          state_d = ROTATE;
        end
      end
      ROTATE: begin
        if (z_q[W-1]) begin
          x_d = x_q + y_sh;
          y_d = y_q - x_sh;
          z_d = z_q + atan_c;
        end else begin
          x_d = x_q - y_sh;
          y_d = y_q + x_sh;
          z_d = z_q - atan_c;
        end
        i_d = i_q + 1'b1;
        if (i_q == BW_SHIFT_VALUE'(N_ITER - 1)) state_d = DONE;
      end
      DONE: begin
        cos_d   = sat(x_q);
        sin_d   = sat(y_q);
        valid_d = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      x_q     <= '0;
      y_q     <= '0;
      z_q     <= '0;
      i_q     <= '0;
      cos_q   <= '0;
      sin_q   <= '0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      x_q     <= x_d;
      y_q     <= y_d;
      z_q     <= z_d;
      i_q     <= i_d;
      cos_q   <= cos_d;
      sin_q   <= sin_d;
      valid_q <= valid_d;
    end
  end

  assign io.ready_o = (state_q == IDLE);
  assign io.cos_o   = cos_q;
  assign io.sin_o   = sin_q;
  assign io.valid_o = valid_q;
endmodule

// File: tb/tb_cordic_rotation_engine.sv
// Directed-vector bench for cordic_rotation_engine: angle table plus
// back-to-back and mid-rotation reset sequences.
module tb_cordic_rotation_engine;
  localparam int N_FRAC = 15;
  localparam int N_ITER = 15;
  localparam int TOL    = 8;

  logic clk = 1'b0;
  logic rst_i;
  int   tests = 0;
  int   failed = 0;

  cordic_rotation_engine_if #(.N_FRAC(N_FRAC)) io ();

  cordic_rotation_engine #(.N_FRAC(N_FRAC), .BW_SHIFT_VALUE(4), .N_ITER(N_ITER)) dut (
    .clk_i (clk),
    .rst_i (rst_i),
    .io    (io)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] angle;
    int          exp_cos;
    int          exp_sin;
  } vec_t;

  task automatic check(input string nm, input int got, input int exp, input int tol);
    tests++;
    if (got > exp + tol || got < exp - tol) begin
      failed++;
      $display("FAIL %s: got %0d, expected %0d (+/-%0d)", nm, got, exp, tol);
    end
  endtask

  // Called at a negedge; returns the result and the cycle index (accept cycle = 0)
  // in which valid_o was seen, plus ready_o in the cycle right after accept.
  task automatic run_vec(input logic [15:0] ang, output int cs, output int sn,
                         output int lat, output int rdy1);
    int guard;
    guard = 0;
    while (!io.ready_o && guard < 100) begin @(negedge clk); guard++; end
    io.angle_i = ang;
    io.valid_i = 1'b1;
    @(posedge clk);
    @(negedge clk);
    io.valid_i = 1'b0;
    rdy1 = int'(io.ready_o);
    lat = 1;
    while (!io.valid_o && lat < 60) begin @(negedge clk); lat++; end
    cs = int'($signed(io.cos_o));
    sn = int'($signed(io.sin_o));
  endtask

  initial begin
    vec_t vecs[8];
    int cs, sn, lat, rdy1, cyc, npulse, first_at, second_at;

    vecs[0] = '{16'h0000,  32767,      0};
    vecs[1] = '{16'h2000,  23170,  23170};
    vecs[2] = '{16'h4000,      0,  32767};
    vecs[3] = '{16'hC000,      0, -32767};
    vecs[4] = '{16'h8000, -32767,      0};
    vecs[5] = '{16'hE000,  23170, -23170};
    vecs[6] = '{16'h6000, -23170,  23170};
    vecs[7] = '{16'hA000, -23170, -23170};

    io.angle_i = '0;
    io.valid_i = 1'b0;
    rst_i = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset ready_o", int'(io.ready_o), 1, 0);
    check("reset valid_o", int'(io.valid_o), 0, 0);
    check("reset cos_o", int'($signed(io.cos_o)), 0, 0);
    check("reset sin_o", int'($signed(io.sin_o)), 0, 0);
    rst_i = 1'b0;
    @(negedge clk);

    for (int v = 0; v < 8; v++) begin
      run_vec(vecs[v].angle, cs, sn, lat, rdy1);
      check($sformatf("vec%0d cos", v), cs, vecs[v].exp_cos, TOL);
      check($sformatf("vec%0d sin", v), sn, vecs[v].exp_sin, TOL);
      check($sformatf("vec%0d latency", v), lat, N_ITER + 2, 0);
      check($sformatf("vec%0d ready low after accept", v), rdy1, 0, 0);
      @(negedge clk);
      check($sformatf("vec%0d valid_o single pulse", v), int'(io.valid_o), 0, 0);
      check($sformatf("vec%0d cos held", v), int'($signed(io.cos_o)), vecs[v].exp_cos, TOL);
    end

    // valid_i held high: pi/8 accepted, then 3pi/4 shown during ROTATE must be ignored
    // until the engine returns to IDLE, where it is accepted back-to-back.
    io.angle_i = 16'h1000;
    io.valid_i = 1'b1;
    @(posedge clk);
    @(negedge clk);
    io.angle_i = 16'h6000;
    npulse = 0; first_at = -1; second_at = -1;
    for (cyc = 1; cyc < 60; cyc++) begin
      if (io.valid_o) begin
        npulse++;
        if (npulse == 1) begin
          first_at = cyc;
          check("hold r1 cos", int'($signed(io.cos_o)), 30274, TOL);
          check("hold r1 sin", int'($signed(io.sin_o)), 12540, TOL);
          check("hold ready with valid_o", int'(io.ready_o), 1, 0);
        end else if (npulse == 2) begin
          second_at = cyc;
          check("hold r2 cos", int'($signed(io.cos_o)), -23170, TOL);
          check("hold r2 sin", int'($signed(io.sin_o)), 23170, TOL);
        end
      end
      if (first_at > 0 && cyc == first_at + 1) io.valid_i = 1'b0;
      if (first_at > 0 && cyc == first_at + 5)
        check("hold old cos kept mid-rotate", int'($signed(io.cos_o)), 30274, TOL);
      @(negedge clk);
    end
    check("hold first pulse cycle", first_at, N_ITER + 2, 0);
    check("hold pulse spacing", second_at - first_at, N_ITER + 2, 0);
    check("hold pulse count", npulse, 2, 0);

    // Reset mid-ROTATE discards the computation
    io.angle_i = 16'h2000;
    io.valid_i = 1'b1;
    @(posedge clk);
    @(negedge clk);
    io.valid_i = 1'b0;
    repeat (5) @(negedge clk);
    rst_i = 1'b1;
    @(negedge clk);
    rst_i = 1'b0;
    check("rst mid ready_o", int'(io.ready_o), 1, 0);
    check("rst mid valid_o", int'(io.valid_o), 0, 0);
    check("rst mid cos_o", int'($signed(io.cos_o)), 0, 0);
    check("rst mid sin_o", int'($signed(io.sin_o)), 0, 0);
    npulse = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (io.valid_o) npulse++;
    end
    check("rst aborted no valid_o", npulse, 0, 0);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end
endmodule
